// File: rtl/hybrid_pkg.sv
// Shared state encoding and gate patterns for the sigma-driven full-bridge driver.
package hybrid_pkg;

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_POS    = 3'd1,
      ST_DT_NEG = 3'd2,
      ST_NEG    = 3'd3,
      ST_DT_POS = 3'd4
   } bridge_state_t;

   // Bit order is {S1, S2, S3, S4}.
   localparam logic [3:0] GATES_OFF = 4'b0000;
   localparam logic [3:0] GATES_POS = 4'b1001;
   localparam logic [3:0] GATES_NEG = 4'b0110;

   function automatic logic [3:0] gates_for(input bridge_state_t st);
      logic [3:0] g;
      g = GATES_OFF;
      case (st)
         ST_POS:  g = GATES_POS;
         ST_NEG:  g = GATES_NEG;
         default: g = GATES_OFF;
      endcase
      return g;
   endfunction

   function automatic logic is_dead_time(input bridge_state_t st);
      return (st == ST_DT_POS) || (st == ST_DT_NEG);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-stage flip-flop synchronizer for a single bit, cleared by an async active-low reset.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic i_CLK,
   input  logic i_RESET,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] sync_reg;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge i_CLK or negedge i_RESET) begin
               if (!i_RESET) sync_reg[gi] <= 1'b0;
               else          sync_reg[gi] <= i_d;
            end
         end else begin : g_chain
            always_ff @(posedge i_CLK or negedge i_RESET) begin
               if (!i_RESET) sync_reg[gi] <= 1'b0;
               else          sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign o_q = sync_reg[STAGES-1];

endmodule

// File: rtl/sigma_bridge_driver.sv
// Full-bridge gate driver: turns the hybrid controller's sigma into diagonal gate
// commands with programmable dead time and a minimum dwell per conduction state.
module sigma_bridge_driver
   import hybrid_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DT_W        = 8,
   parameter int DWELL_W     = 16,
   parameter int CNT_W       = 16
) (
   input  logic               i_CLK,
   input  logic               i_RESET,
   input  logic               i_sigma,
   input  logic               i_enable,
   input  logic [DT_W-1:0]    i_deadtime,
   input  logic [DWELL_W-1:0] i_min_dwell,
   output logic               o_S1,
   output logic               o_S2,
   output logic               o_S3,
   output logic               o_S4,
   output logic               o_sigma_applied,
   output logic               o_busy,
   output logic [CNT_W-1:0]   o_switch_count
);

   localparam logic [DT_W-1:0]    DT_ONE    = 1;
   localparam logic [DWELL_W-1:0] DWELL_ONE = 1;
   localparam logic [CNT_W-1:0]   CNT_ONE   = 1;

   logic                sigma_s;
   bridge_state_t       state_reg, state_next;
   logic [DT_W-1:0]     dt_cnt_reg;
   logic [DWELL_W-1:0]  dwell_cnt_reg;
   logic [3:0]          gates_reg;
   logic                sigma_applied_reg;
   logic                busy_reg;
   logic [CNT_W-1:0]    switch_count_reg;

   logic [DT_W-1:0]     dt_eff;
   logic [DWELL_W-1:0]  dwell_eff;
   logic [DWELL_W:0]    dwell_plus1;
   logic                dwell_met;
   logic                entering;
   logic                enter_pos, enter_neg;

   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sigma_sync (
      .i_CLK   (i_CLK),
      .i_RESET (i_RESET),
      .i_d     (i_sigma),
      .o_q     (sigma_s)
   );

   // Zero settings are promoted to one cycle so dead time and dwell never vanish.
   assign dt_eff      = (i_deadtime == '0)  ? DT_ONE    : i_deadtime;
   assign dwell_eff   = (i_min_dwell == '0) ? DWELL_ONE : i_min_dwell;
   assign dwell_plus1 = {1'b0, dwell_cnt_reg} + {{DWELL_W{1'b0}}, 1'b1};
   assign dwell_met   = dwell_plus1 >= {1'b0, dwell_eff};

   always_comb begin
      state_next = state_reg;
      if (!i_enable) begin
         state_next = ST_OFF;
      end else begin
         case (state_reg)
            ST_OFF:    state_next = sigma_s ? ST_DT_POS : ST_DT_NEG;
            ST_DT_POS: if (dt_cnt_reg <= DT_ONE) state_next = ST_POS;
            ST_DT_NEG: if (dt_cnt_reg <= DT_ONE) state_next = ST_NEG;
            ST_POS:    if (!sigma_s && dwell_met) state_next = ST_DT_NEG;
            ST_NEG:    if (sigma_s && dwell_met)  state_next = ST_DT_POS;
            default:   state_next = ST_OFF;
         endcase
      end
   end

   assign entering  = (state_next != state_reg);
   assign enter_pos = (state_next == ST_POS) && (state_reg == ST_DT_POS);
   assign enter_neg = (state_next == ST_NEG) && (state_reg == ST_DT_NEG);

   // Outputs decode from state_next so gates change on the same edge as the state.
   always_ff @(posedge i_CLK or negedge i_RESET) begin
      if (!i_RESET) begin
         state_reg         <= ST_OFF;
         gates_reg         <= GATES_OFF;
         busy_reg          <= 1'b0;
         sigma_applied_reg <= 1'b0;
         switch_count_reg  <= '0;
      end else begin
         state_reg <= state_next;
         gates_reg <= gates_for(state_next);
         busy_reg  <= is_dead_time(state_next);
         if (enter_pos) begin
            sigma_applied_reg <= 1'b1;
            if (!sigma_applied_reg) switch_count_reg <= switch_count_reg + CNT_ONE;
         end else if (enter_neg) begin
            sigma_applied_reg <= 1'b0;
            if (sigma_applied_reg) switch_count_reg <= switch_count_reg + CNT_ONE;
         end
      end
   end

   always_ff @(posedge i_CLK or negedge i_RESET) begin
      if (!i_RESET) begin
         dt_cnt_reg    <= '0;
         dwell_cnt_reg <= '0;
      end else begin
         if (is_dead_time(state_next)) begin
            dt_cnt_reg <= entering ? dt_eff : (dt_cnt_reg - DT_ONE);
         end
         if ((state_next == ST_POS) || (state_next == ST_NEG)) begin
            if (entering)                dwell_cnt_reg <= '0;
            else if (dwell_cnt_reg != '1) dwell_cnt_reg <= dwell_cnt_reg + DWELL_ONE;
         end
      end
   end

   assign o_S1            = gates_reg[3];
   assign o_S2            = gates_reg[2];
   assign o_S3            = gates_reg[1];
   assign o_S4            = gates_reg[0];
   assign o_busy          = busy_reg;
   assign o_sigma_applied = sigma_applied_reg;
   assign o_switch_count  = switch_count_reg;

endmodule

// File: tb/tb_sigma_bridge_driver.sv
// Self-checking bench for sigma_bridge_driver: cycle model plus directed scenarios.
module tb_sigma_bridge_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sigma;
   logic        enable;
   logic [7:0]  deadtime;
   logic [15:0] min_dwell;
   logic        o_S1, o_S2, o_S3, o_S4;
   logic        o_sigma_applied, o_busy;
   logic [15:0] o_switch_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sigma_bridge_driver #(
      .SYNC_STAGES (2),
      .DT_W        (8),
      .DWELL_W     (16),
      .CNT_W       (16)
   ) dut (
      .i_CLK           (clk),
      .i_RESET         (rst_n),
      .i_sigma         (sigma),
      .i_enable        (enable),
      .i_deadtime      (deadtime),
      .i_min_dwell     (min_dwell),
      .o_S1            (o_S1),
      .o_S2            (o_S2),
      .o_S3            (o_S3),
      .o_S4            (o_S4),
      .o_sigma_applied (o_sigma_applied),
      .o_busy          (o_busy),
      .o_switch_count  (o_switch_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: mode 0 = off, 1 = dead time, 2 = conducting.
   localparam int M_OFF = 0, M_DT = 1, M_ON = 2;
   logic        m_sync0, m_sync1;
   int          m_mode, m_dt_left, m_dwell;
   logic        m_pol, m_applied;
   logic [15:0] m_count;

   initial begin
      m_sync0 = 0; m_sync1 = 0; m_mode = M_OFF; m_pol = 0;
      m_dt_left = 0; m_dwell = 0; m_applied = 0; m_count = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_sync0 = 0; m_sync1 = 0; m_mode = M_OFF; m_pol = 0;
            m_dt_left = 0; m_dwell = 0; m_applied = 0; m_count = 0;
         end else begin
            automatic logic s = m_sync1;
            automatic int dt_set = (deadtime == 0) ? 1 : int'(deadtime);
            automatic int dw_set = (min_dwell == 0) ? 1 : int'(min_dwell);
            m_sync1 = m_sync0;
            m_sync0 = sigma;
            if (!enable) begin
               m_mode = M_OFF;
            end else if (m_mode == M_OFF) begin
               m_mode = M_DT; m_pol = s; m_dt_left = dt_set;
            end else if (m_mode == M_DT) begin
               if (m_dt_left <= 1) begin
                  m_mode = M_ON;
                  m_dwell = 0;
                  if (m_pol != m_applied) m_count = m_count + 16'd1;
                  m_applied = m_pol;
               end else begin
                  m_dt_left = m_dt_left - 1;
               end
            end else begin
               if (s != m_pol && m_dwell + 1 >= dw_set) begin
                  m_mode = M_DT; m_pol = s; m_dt_left = dt_set;
               end else if (m_dwell < 65535) begin
                  m_dwell = m_dwell + 1;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         begin
            automatic logic on = (m_mode == M_ON);
            automatic logic [3:0] exp_g = {on & m_pol, on & ~m_pol, on & ~m_pol, on & m_pol};
            check("gates", {28'd0, o_S1, o_S2, o_S3, o_S4}, {28'd0, exp_g});
            check("busy", {31'd0, o_busy}, {31'd0, (m_mode == M_DT)});
            check("applied", {31'd0, o_sigma_applied}, {31'd0, m_applied});
            check("count", {16'd0, o_switch_count}, {16'd0, m_count});
            check("shoot_through", {31'd0, (o_S1 & o_S2) | (o_S3 & o_S4)}, 32'd0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   int n, k;

   initial begin
      rst_n = 0; enable = 0; sigma = 1; deadtime = 8'd5; min_dwell = 16'd10;
      #22 rst_n = 1;
      tick(3);

      // Reset/enable: 5 dead cycles then POS.
      enable = 1;
      n = 0;
      for (k = 0; k < 50; k++) begin
         tick(1);
         if (o_busy) n++;
         if (o_S1) break;
      end
      check("first_dt_len", n, 5);
      check("first_pos", {30'd0, o_S1, o_S4}, 32'd3);
      check("first_count", {16'd0, o_switch_count}, 32'd1);
      check("first_applied", {31'd0, o_sigma_applied}, 32'd1);

      // Normal toggling.
      deadtime = 8'd3; min_dwell = 16'd10;
      for (int t = 0; t < 4; t++) begin
         sigma = ~sigma;
         n = 0;
         for (int c = 0; c < 40; c++) begin
            tick(1);
            if (o_busy) n++;
         end
         check("toggle_dt_len", n, 3);
      end
      check("toggle_count", {16'd0, o_switch_count}, 32'd5);

      // Dwell enforcement.
      min_dwell = 16'd50;
      sigma = 0;
      k = 0;
      while (!o_S2 && k < 200) begin tick(1); k++; end
      check("dwell_reach_neg", {31'd0, o_S2}, 32'd1);
      sigma = 1;
      k = 0;
      while (!o_S1 && k < 200) begin tick(1); k++; end
      check("dwell_reach_pos", {31'd0, o_S1}, 32'd1);
      n = 1;
      for (k = 0; k < 200; k++) begin
         if (n == 5) sigma = 0;
         tick(1);
         if (o_S1) n++;
         else break;
      end
      check("dwell_pos_len", n, 50);
      k = 0;
      while (!o_S2 && k < 50) begin tick(1); k++; end
      check("dwell_count", {16'd0, o_switch_count}, 32'd8);
      tick(10);
      sigma = 1; tick(3); sigma = 0;
      tick(60);
      check("pulse_dropped_neg", {31'd0, o_S2}, 32'd1);
      check("pulse_dropped_count", {16'd0, o_switch_count}, 32'd8);

      // Zero settings with sigma toggling every cycle.
      deadtime = 8'd0; min_dwell = 16'd0;
      repeat (20) begin sigma = ~sigma; tick(1); end
      sigma = 1;
      tick(8);
      check("zero_settle_pos", {31'd0, o_S1}, 32'd1);

      // Disable on the 2nd cycle of an 8-cycle dead time.
      deadtime = 8'd8; min_dwell = 16'd1;
      tick(5);
      sigma = 0;
      k = 0;
      while (!o_busy && k < 20) begin tick(1); k++; end
      check("dis_enter_dt", {31'd0, o_busy}, 32'd1);
      tick(1);
      enable = 0;
      tick(1);
      check("dis_gates_off", {28'd0, o_S1, o_S2, o_S3, o_S4}, 32'd0);
      check("dis_not_busy", {31'd0, o_busy}, 32'd0);
      tick(3);
      enable = 1;
      n = 0;
      for (k = 0; k < 50; k++) begin
         tick(1);
         if (o_busy) n++;
         if (o_S2) break;
      end
      check("reen_dt_len", n, 8);
      check("reen_neg", {31'd0, o_S2 & o_S3}, 32'd1);

      // Counter wrap, then async reset mid-POS.
      deadtime = 8'd2;
      sigma = 1;
      k = 0;
      while (!o_S1 && k < 60) begin tick(1); k++; end
      force dut.switch_count_reg = 16'hFFFF;
      m_count = 16'hFFFF;
      #1 release dut.switch_count_reg;
      sigma = 0;
      k = 0;
      while (!o_S2 && k < 60) begin tick(1); k++; end
      check("wrap_to_zero", {16'd0, o_switch_count}, 32'd0);
      sigma = 1;
      k = 0;
      while (!o_S1 && k < 60) begin tick(1); k++; end
      check("after_wrap", {16'd0, o_switch_count}, 32'd1);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      check("async_gates", {28'd0, o_S1, o_S2, o_S3, o_S4}, 32'd0);
      check("async_count", {16'd0, o_switch_count}, 32'd0);
      check("async_applied", {31'd0, o_sigma_applied}, 32'd0);
      check("async_busy", {31'd0, o_busy}, 32'd0);
      tick(2);
      rst_n = 1;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
